multiport_regfile: RTL and testbench

//  Parametrised 2-read/2-write register file for the next-generation datapath core.
//  Two registered read ports with optional write-to-read bypass, and two write ports with fixed priority.
//  Per-register busy scoreboard for the issue stage; combinational debug read port.

---
 rtl/multiport_regfile.sv | 101 ++++++++++
 tb/tb_multiport_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multiport_regfile.sv
// Two-read / two-write register file with registered read ports, optional
// write-to-read forwarding, and a per-register busy scoreboard for issue.
module multiport_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       addra,
  output logic [DATA_W-1:0]       dataa,
  input  logic [ADDR_W-1:0]       addrb,
  output logic [DATA_W-1:0]       datab,
  output logic                    busya,
  output logic                    busyb,
  input  logic                    wen0,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    wen1,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic                    set_busy,
  input  logic [ADDR_W-1:0]       set_addr,
  output logic [(1<<ADDR_W)-1:0]  busy_vec,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  hit0, hit1, set_hit;
  logic [DATA_W-1:0] rd_val_a, rd_val_b;

  // One-hot per-register decode of each lane; register 0 is masked out here so
  // the write, forward and scoreboard paths all see it as untouchable.
  always_comb begin
    hit0    = '0;
    hit1    = '0;
    set_hit = '0;
    if (wen0)     hit0[waddr0]      = 1'b1;
    if (wen1)     hit1[waddr1]      = 1'b1;
    if (set_busy) set_hit[set_addr] = 1'b1;
    if (ZERO_REG != 0) begin
      hit0[0]    = 1'b0;
      hit1[0]    = 1'b0;
      set_hit[0] = 1'b0;
    end
  end

  always_comb begin
    rd_val_a = regs[addra];
    rd_val_b = regs[addrb];
    if (BYPASS != 0) begin
      if (hit1[addra])      rd_val_a = wdata1;
      else if (hit0[addra]) rd_val_a = wdata0;
      if (hit1[addrb])      rd_val_b = wdata1;
      else if (hit0[addrb]) rd_val_b = wdata0;
    end
    if ((ZERO_REG != 0) && (addra == '0)) rd_val_a = '0;
    if ((ZERO_REG != 0) && (addrb == '0)) rd_val_b = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[ADDR_W'(i)] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (hit1[i])      regs[ADDR_W'(i)] <= wdata1;
        else if (hit0[i]) regs[ADDR_W'(i)] <= wdata0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataa <= '0;
      datab <= '0;
    end else if (rd_en) begin
      dataa <= rd_val_a;
      datab <= rd_val_b;
    end
  end

  // A new producer issuing wins over a retiring write to the same register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= set_hit | (busy_vec & ~(hit0 | hit1));
      if (ZERO_REG != 0) busy_vec[0] <= 1'b0;
    end
  end

  assign busya    = busy_vec[addra];
  assign busyb    = busy_vec[addrb];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: forwarding and non-forwarding instances share
// stimulus and are checked every cycle against a behavioural array model.
`timescale 1ns/100ps
module tb_multiport_regfile;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  addra = '0, addrb = '0, waddr0 = '0, waddr1 = '0, set_addr = '0, dbg_addr = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        wen0 = 1'b0, wen1 = 1'b0, set_busy = 1'b0;

  logic [31:0] dataa_b, datab_b, dbg_b, dataa_n, datab_n, dbg_n;
  logic        busya_b, busyb_b, busya_n, busyb_n;
  logic [31:0] bvec_b, bvec_n;

  int checks = 0;
  int failures = 0;

  multiport_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clock(clock), .reset(reset), .rd_en(rd_en),
    .addra(addra), .dataa(dataa_b), .addrb(addrb), .datab(datab_b),
    .busya(busya_b), .busyb(busyb_b),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .set_busy(set_busy), .set_addr(set_addr), .busy_vec(bvec_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b));

  multiport_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nob (
    .clock(clock), .reset(reset), .rd_en(rd_en),
    .addra(addra), .dataa(dataa_n), .addrb(addrb), .datab(datab_n),
    .busya(busya_n), .busyb(busyb_n),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .set_busy(set_busy), .set_addr(set_addr), .busy_vec(bvec_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_n));

  always #5 clock = ~clock;

  // Behavioural model
  logic [31:0] m_mem [32];
  logic        m_busy [32];
  logic [31:0] m_a_b, m_b_b, m_a_n, m_b_n;

  function automatic logic [31:0] model_read(input logic [4:0] x, input bit byp);
    if (x == 0) return 32'h0;
    if (byp && wen1 && waddr1 == x) return wdata1;
    if (byp && wen0 && waddr0 == x) return wdata0;
    return m_mem[x];
  endfunction

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = 32'h0; m_busy[i] = 1'b0; end
      m_a_b = 0; m_b_b = 0; m_a_n = 0; m_b_n = 0;
    end else begin
      if (rd_en) begin
        m_a_b = model_read(addra, 1'b1); m_b_b = model_read(addrb, 1'b1);
        m_a_n = model_read(addra, 1'b0); m_b_n = model_read(addrb, 1'b0);
      end
      // Writes apply lane 0 then lane 1 so lane 1 ends up on top.
      if (wen0 && waddr0 != 0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
      if (wen1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
      if (set_busy && set_addr != 0) m_busy[set_addr] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    chk("dataa_byp", dataa_b, m_a_b);
    chk("datab_byp", datab_b, m_b_b);
    chk("dataa_nob", dataa_n, m_a_n);
    chk("datab_nob", datab_n, m_b_n);
    chk("busy_vec_byp", bvec_b, model_busy_vec());
    chk("busy_vec_nob", bvec_n, model_busy_vec());
    chk("busya", {31'b0, busya_b}, {31'b0, m_busy[addra]});
    chk("busyb", {31'b0, busyb_b}, {31'b0, m_busy[addrb]});
    chk("busya_nob", {31'b0, busya_n}, {31'b0, m_busy[addra]});
    chk("dbg_byp", dbg_b, m_mem[dbg_addr]);
    chk("dbg_nob", dbg_n, m_mem[dbg_addr]);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wen0 = 0; wen1 = 0; set_busy = 0; rd_en = 0;
  endtask

  initial begin
    step(); step();
    chk("reset_dataa", dataa_b, 32'h0);
    chk("reset_busy_vec", bvec_b, 32'h0);
    reset = 1'b1;
    step();

    // Latency and hold
    wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    step();
    idle(); addra = 5; rd_en = 1;
    step();
    chk("latency_dataa", dataa_b, 32'hDEADBEEF);
    chk("latency_dataa_nob", dataa_n, 32'hDEADBEEF);
    idle(); wen1 = 1; waddr1 = 5; wdata1 = 32'h12345678;
    step();
    idle();
    step();
    dbg_addr = 5; #0.1;
    chk("hold_dataa", dataa_b, 32'hDEADBEEF);
    chk("rewrite_dbg", dbg_b, 32'h12345678);

    // Write collision with forwarding
    wen0 = 1; waddr0 = 7; wdata0 = 32'hAAAA0000;
    step();
    idle();
    wen0 = 1; waddr0 = 7; wdata0 = 32'h11111111;
    wen1 = 1; waddr1 = 7; wdata1 = 32'h22222222;
    addra = 7; addrb = 5; rd_en = 1;
    step();
    idle(); dbg_addr = 7; #0.1;
    chk("collide_dbg", dbg_b, 32'h22222222);
    chk("collide_dataa_byp", dataa_b, 32'h22222222);
    chk("collide_dataa_nob", dataa_n, 32'hAAAA0000);
    chk("collide_datab", datab_b, 32'h12345678);

    // Zero register
    wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF;
    wen1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF;
    set_busy = 1; set_addr = 0; addra = 0; addrb = 0; rd_en = 1;
    step();
    idle(); dbg_addr = 0; #0.1;
    chk("zero_dataa", dataa_b, 32'h0);
    chk("zero_dbg", dbg_b, 32'h0);
    chk("zero_busy", {31'b0, bvec_b[0]}, 32'h0);

    // Scoreboard
    set_busy = 1; set_addr = 3; addra = 3;
    step();
    idle();
    chk("sb_set_busya", {31'b0, busya_b}, 32'h1);
    wen0 = 1; waddr0 = 3; wdata0 = 32'h00000033;
    step();
    idle();
    chk("sb_clear_busya", {31'b0, busya_b}, 32'h0);
    set_busy = 1; set_addr = 3; wen1 = 1; waddr1 = 3; wdata1 = 32'h00000044;
    step();
    idle();
    chk("sb_set_wins", {31'b0, bvec_b[3]}, 32'h1);
    wen1 = 1; waddr1 = 3; wdata1 = 32'h55;
    step();
    idle();
    chk("sb_lane1_clear", {31'b0, bvec_b[3]}, 32'h0);

    // Mixed traffic, checked by the per-cycle compare
    for (int i = 0; i < 60; i++) begin
      wen0 = 1'($urandom); waddr0 = 5'($urandom_range(0, 7)); wdata0 = $urandom;
      wen1 = 1'($urandom); waddr1 = 5'($urandom_range(0, 7)); wdata1 = $urandom;
      set_busy = 1'($urandom); set_addr = 5'($urandom_range(0, 7));
      rd_en = 1'($urandom); addra = 5'($urandom_range(0, 7)); addrb = 5'($urandom_range(0, 7));
      dbg_addr = 5'($urandom_range(0, 7));
      step();
    end
    idle();

    // Asynchronous reset mid-cycle with writes and sets pending
    wen0 = 1; waddr0 = 9; wdata0 = 32'h99;
    set_busy = 1; set_addr = 10; rd_en = 1; addra = 1; addrb = 2;
    #2 reset = 1'b0;
    #0.1;
    chk("rst_dataa", dataa_b, 32'h0);
    chk("rst_datab", datab_b, 32'h0);
    chk("rst_busy_vec", bvec_b, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #0.05;
      chk("rst_dbg", dbg_b, 32'h0);
    end
    step();
    idle();
    reset = 1'b1;
    step();
    dbg_addr = 9; #0.1;
    chk("rst_write_lost", dbg_b, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
